// File: rtl/shift_pkg.sv
// shift_pkg: shared types and helpers for the pipelined right shifter
package shift_pkg;
  typedef enum logic {SHIFT_LOGIC = 1'b0, SHIFT_ARITH = 1'b1} shift_mode_e;
  function automatic int STAGES(input int width);
    int n;
    for (n = 0; (1 << n) < width; n++) ;
    return (n < 1) ? 1 : n;
  endfunction
  localparam int DATA_W = 8;
  localparam int AMT_W = STAGES(DATA_W);
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [AMT_W-1:0]  amt;
    logic              sign;
    shift_mode_e       mode;
    logic              valid;
  } stage_t;
endpackage

// File: rtl/shift_right_stage.sv
// shift_right_stage: one registered conditional right shift by DIST with valid/ready
module shift_right_stage
  import shift_pkg::*;
#(
  parameter int WIDTH = DATA_W,
  parameter int DIST  = 1
) (
  input  logic   clk,
  input  logic   rst,
  input  stage_t up,
  output logic   up_ready,
  output stage_t dn,
  input  logic   dn_ready
);
  localparam int K = $clog2(DIST);
  logic fill;
  logic [WIDTH-1:0] shifted;
  assign fill = (up.mode == SHIFT_ARITH) && up.sign;
  assign shifted = WIDTH'({{WIDTH{fill}}, up.data} >> DIST);
  // load when empty or when the downstream drains us this cycle
  assign up_ready = !dn.valid || dn_ready;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) dn <= '0;
    else if (up_ready)
      dn <= '{data: up.amt[K] ? shifted : up.data, amt: up.amt, sign: up.sign,
              mode: up.mode, valid: up.valid};
  end
endmodule

// File: rtl/shift_right_pipe_8.sv
// shift_right_pipe_8: pipelined logical/arithmetic right shifter, one stage per amount bit
module shift_right_pipe_8
  import shift_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             arith,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s
);
  localparam int SHW = STAGES(WIDTH);
  stage_t [SHW:0] st;
  logic   [SHW:0] rdy;
  logic unused;
  assign st[0] = '{data: a, amt: b[SHW-1:0], sign: a[WIDTH-1],
                   mode: shift_mode_e'(arith), valid: in_valid};
  assign rdy[SHW] = out_ready;
  assign in_ready = rdy[0];
  assign s = st[SHW].data;
  assign out_valid = st[SHW].valid;
  // amounts >= WIDTH wrap: the high b bits are simply dropped
  assign unused = ^{b[WIDTH-1:SHW], st[SHW].amt, st[SHW].sign, st[SHW].mode};
  for (genvar k = 0; k < SHW; k++) begin : g_stage
    shift_right_stage #(.WIDTH(WIDTH), .DIST(1 << k)) u_stage (
      .clk      (clk),
      .rst      (rst),
      .up       (st[k]),
      .up_ready (rdy[k]),
      .dn       (st[k+1]),
      .dn_ready (rdy[k+1])
    );
  end
endmodule

// File: tb/tb_shift_right_pipe_8.sv
// tb_shift_right_pipe_8: directed vectors plus a per-cycle model scoreboard
module tb_shift_right_pipe_8;
  logic clk = 0, rst = 1, in_valid = 0, arith = 0, out_ready = 1;
  logic [7:0] a = 0, b = 0;
  logic in_ready, out_valid;
  logic [7:0] s;
  int checks = 0, failures = 0;
  logic [7:0] exp_q[$];
  logic [7:0] prev_s;
  logic prev_stall = 0;

  shift_right_pipe_8 dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .arith(arith), .out_valid(out_valid), .out_ready(out_ready), .s(s)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] model(input logic [7:0] x, input logic [7:0] amt, input logic ar);
    int n = int'(amt) % 8;
    logic signed [7:0] sx = x;
    logic [7:0] r;
    if (ar) r = sx >>> n;
    else r = x >> n;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      prev_stall = 0;
    end else begin
      if (prev_stall) chk("hold", {out_valid, s}, {1'b1, prev_s});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("spurious_out", 1, 0);
        else chk("model_s", s, exp_q.pop_front());
      end
      if (in_valid && in_ready) exp_q.push_back(model(a, b, arith));
      prev_stall = out_valid && !out_ready;
      prev_s = s;
    end
  end

  assert property (@(posedge clk) disable iff (rst) out_valid && !out_ready |=> out_valid && $stable(s));

  task automatic one(input string name, input logic [7:0] va, input logic [7:0] vb, input logic ar,
                     input logic [7:0] req);
    int n = 1;
    a = va; b = vb; arith = ar; in_valid = 1; out_ready = 1;
    chk({name, "_in_ready"}, in_ready, 1);
    tick;
    in_valid = 0;
    while (!out_valid && n < 10) begin
      tick;
      n++;
    end
    chk({name, "_latency"}, n, 3);
    chk({name, "_s"}, s, req);
    tick;
  endtask

  logic [7:0] got[$];
  int first, last, acc;
  logic [7:0] exp4 [8] = '{8'h00, 8'h01, 8'h01, 8'h02, 8'h02, 8'h03, 8'h03, 8'h04};

  initial begin
    chk("model_pin_sra", model(8'hB4, 8'h02, 1), 8'hED);
    chk("model_pin_wrap", model(8'hF0, 8'h0A, 0), 8'h3C);
    tick; tick;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_s", s, 0);
    rst = 0;
    #1;
    chk("reset_in_ready", in_ready, 1);
    one("srl_b4_2", 8'hB4, 8'h02, 0, 8'h2D);
    one("sra_b4_2", 8'hB4, 8'h02, 1, 8'hED);
    one("srl_80_7", 8'h80, 8'h07, 0, 8'h01);
    one("sra_80_7", 8'h80, 8'h07, 1, 8'hFF);
    one("sra_7f_0", 8'h7F, 8'h00, 1, 8'h7F);
    one("srl_wrap", 8'hF0, 8'h0A, 0, 8'h3C);
    // streaming, one beat per cycle
    first = -1; last = -1;
    b = 8'h01; arith = 0; out_ready = 1;
    for (int i = 0; i < 16; i++) begin
      in_valid = (i < 8);
      a = 8'(i + 1);
      if (i < 8) chk("stream_in_ready", in_ready, 1);
      tick;
      if (out_valid) begin
        got.push_back(s);
        if (first < 0) first = i;
        last = i;
      end
    end
    in_valid = 0;
    chk("stream_count", got.size(), 8);
    chk("stream_span", last - first, 7);
    for (int i = 0; i < 8 && i < got.size(); i++) chk("stream_s", got[i], exp4[i]);
    // backpressure fills exactly SHW stages
    out_ready = 0; in_valid = 1; b = 8'h01; arith = 0; acc = 0;
    a = 8'h11;
    for (int i = 0; i < 6; i++) begin
      if (in_ready) begin
        acc++;
        tick;
        a = 8'(8'h11 * (acc + 1));
      end else tick;
    end
    chk("bp_accepted", acc, 3);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_out_valid", out_valid, 1);
    chk("bp_s", s, 8'h08);
    in_valid = 0; out_ready = 1;
    #1;
    chk("bp_release_in_ready", in_ready, 1);
    chk("bp_drain0", s, 8'h08);
    tick;
    chk("bp_drain1", s, 8'h11);
    tick;
    chk("bp_drain2", s, 8'h19);
    tick;
    chk("bp_empty", out_valid, 0);
    // async reset with beats in flight
    in_valid = 1; b = 8'h01; arith = 1; a = 8'hE6;
    tick;
    a = 8'hD2;
    tick;
    in_valid = 0;
    tick;
    chk("pre_reset_out_valid", out_valid, 1);
    rst = 1;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_s", s, 8'h00);
    tick;
    rst = 0;
    #1;
    one("post_reset_sra", 8'hC3, 8'h03, 1, 8'hF8);
    for (int i = 0; i < 4; i++) begin
      tick;
      chk("no_stale", out_valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
